// File: rtl/cpu_test_monitor.sv
// cpu_test_monitor: run controller and end-of-test self-checker for the cpu/rom/ram trio.
// Holds the core in reset, runs it until a tohost store or a cycle timeout, then checks
// probe lanes against expected values and reports a sticky verdict plus run cycle count.
// Optional trace message on verdict: define CPU_TEST_MONITOR_TRACE_EN.
module cpu_test_monitor #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned NUM_PROBES     = 4,
  parameter logic [63:0] TOHOST_ADDR    = 64'h0000_1000,
  parameter int unsigned RESET_CYCLES   = 1,
  parameter int unsigned TIMEOUT_CYCLES = 500,
  parameter int unsigned REQUIRE_TOHOST = 0,
  localparam int unsigned IDX_W = (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1,
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             mem_wr_sig,
  input  logic [ADDR_WIDTH-1:0]            mem_addr,
  input  logic [DATA_WIDTH-1:0]            mem_wr_data,
  input  logic [NUM_PROBES*DATA_WIDTH-1:0] probe_data,
  input  logic [NUM_PROBES*DATA_WIDTH-1:0] expected_data,
  input  logic [NUM_PROBES-1:0]            probe_en,
  output logic                             cpu_reset_n,
  output logic                             done,
  output logic                             pass,
  output logic [1:0]                       fail_code,
  output logic [IDX_W-1:0]                 mismatch_idx,
  output logic [CNT_W-1:0]                 cycle_count
);

  localparam int unsigned HOLD_W = $clog2(RESET_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] TOHOST_A     = ADDR_WIDTH'(TOHOST_ADDR);
  localparam logic [CNT_W-1:0]      TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      TIMEOUT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [HOLD_W-1:0]     HOLD_LAST    = HOLD_W'(RESET_CYCLES);

  localparam logic [1:0] ST_HOLD  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Parameter sanity: refuse to build rather than silently truncate or misbehave.
  if (NUM_PROBES < 1 || NUM_PROBES > 16) begin : g_bad_probes
    $error("cpu_test_monitor: NUM_PROBES must be in 1..16");
  end
  if (RESET_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cycles
    $error("cpu_test_monitor: RESET_CYCLES and TIMEOUT_CYCLES must be >= 1");
  end
  if (ADDR_WIDTH < 64) begin : g_addr_chk
    if ((TOHOST_ADDR >> ADDR_WIDTH) != 64'd0) begin : g_bad_tohost
      $error("cpu_test_monitor: TOHOST_ADDR does not fit in ADDR_WIDTH");
    end
  end

  logic [1:0]            r_state;
  logic [1:0]            w_state_next;
  logic [HOLD_W-1:0]     r_hold_cnt;
  logic                  r_cpu_reset_n;
  logic                  r_done;
  logic                  r_pass;
  logic [1:0]            r_fail_code;
  logic [IDX_W-1:0]      r_mismatch_idx;
  logic [CNT_W-1:0]      r_cycle_count;
  logic                  r_th_seen;
  logic [DATA_WIDTH-1:0] r_th_val;

  logic                  w_tohost_hit;
  logic                  w_timeout;
  logic                  w_mis_any;
  logic [IDX_W-1:0]      w_mis_idx;
  logic [1:0]            w_code;

  assign w_tohost_hit = mem_wr_sig && (mem_addr == TOHOST_A);
  // Count reaches TIMEOUT_CYCLES on this edge.
  assign w_timeout    = (r_cycle_count == TIMEOUT_LAST);

  // Next-state: HOLD -> RUN -> CHECK -> DONE; DONE only leaves through reset_n.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_HOLD:  if (r_hold_cnt == HOLD_LAST) w_state_next = ST_RUN;
      ST_RUN:   if (w_tohost_hit || w_timeout) w_state_next = ST_CHECK;
      ST_CHECK: w_state_next = ST_DONE;
      default:  w_state_next = ST_DONE;
    endcase
  end

  // Lowest enabled lane whose observed value differs from the expected one.
  always_comb begin
    w_mis_any = 1'b0;
    w_mis_idx = '0;
    for (int i = int'(NUM_PROBES) - 1; i >= 0; i--) begin
      if (probe_en[i] &&
          (probe_data[i*DATA_WIDTH +: DATA_WIDTH] != expected_data[i*DATA_WIDTH +: DATA_WIDTH]))
      begin
        w_mis_any = 1'b1;
        w_mis_idx = IDX_W'(i);
      end
    end
  end

  // Verdict priority: missing tohost, bad tohost value, probe mismatch, pass.
  always_comb begin
    w_code = 2'd0;
    if ((REQUIRE_TOHOST != 0) && !r_th_seen) begin
      w_code = 2'd3;
    end else if (r_th_seen && (r_th_val != DATA_WIDTH'(1))) begin
      w_code = 2'd1;
    end else if (w_mis_any) begin
      w_code = 2'd2;
    end
  end

  // State register and the reset hold counter that releases the core.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_HOLD;
      r_hold_cnt    <= '0;
      r_cpu_reset_n <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_HOLD) begin
        if (r_hold_cnt == HOLD_LAST) begin
          r_cpu_reset_n <= 1'b1;
        end else begin
          r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
        end
      end
    end
  end

  // RUN bookkeeping: cycle counter and tohost capture (a store wins over a same-cycle timeout).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cycle_count <= '0;
      r_th_seen     <= 1'b0;
      r_th_val      <= '0;
    end else if (r_state == ST_RUN) begin
      if (r_cycle_count != TIMEOUT_MAX) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
      if (w_tohost_hit) begin
        r_th_seen <= 1'b1;
        r_th_val  <= mem_wr_data;
      end
    end
  end

  // Verdict capture in CHECK; done/pass raised one edge later and then frozen.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fail_code    <= 2'd0;
      r_mismatch_idx <= '0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      r_fail_code    <= w_code;
      r_mismatch_idx <= w_mis_idx;
    end else if ((r_state == ST_DONE) && !r_done) begin
      r_done <= 1'b1;
      r_pass <= (r_fail_code == 2'd0);
    end
  end

`ifdef CPU_TEST_MONITOR_TRACE_EN
  logic [DATA_WIDTH-1:0] r_trace_exp;
  logic [DATA_WIDTH-1:0] r_trace_got;

  // Keep the values behind a failure so the message can quote them.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_trace_exp <= '0;
      r_trace_got <= '0;
    end else if (r_state == ST_CHECK) begin
      if (w_code == 2'd1) begin
        r_trace_exp <= DATA_WIDTH'(1);
        r_trace_got <= r_th_val;
      end else begin
        r_trace_exp <= expected_data[w_mis_idx*DATA_WIDTH +: DATA_WIDTH];
        r_trace_got <= probe_data[w_mis_idx*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // One message per run, on the first DONE cycle.
  always_ff @(posedge clk) begin
    if (reset_n && (r_state == ST_DONE) && !r_done) begin
      if (r_fail_code == 2'd0) begin
        $display("cpu: pass %0d cycles", r_cycle_count);
      end else begin
        $display("cpu: fail code %0d lane %0d expected %0d got %0d",
                 r_fail_code, r_mismatch_idx, r_trace_exp, r_trace_got);
      end
    end
  end
`else
  // Default build: no trace output, verdict logic unchanged.
`endif

  assign cpu_reset_n  = r_cpu_reset_n;
  assign done         = r_done;
  assign pass         = r_pass;
  assign fail_code    = r_fail_code;
  assign mismatch_idx = r_mismatch_idx;
  assign cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_cpu_test_monitor.sv
// Bench for cpu_test_monitor: three instances with different hold/timeout/require settings
// share one stimulus stream; results are checked against a table and a scenario-level model.
module tb_cpu_test_monitor;

  localparam logic [63:0] TOHOST_P  = 64'h0000_1000;
  localparam logic [31:0] TOHOST_32 = 32'h0000_1000;

  typedef struct {
    int               s;      // edge carrying the tohost store, -1 = none
    logic [31:0]      sd;     // tohost store data
    logic [127:0]     pd;     // probe lanes
    logic [127:0]     ed;     // expected lanes
    logic [3:0]       en;
    int               abort;  // edge on which reset_n is pulled low, -1 = none
    logic [2:0][1:0]  code;   // per instance {c, b, a}
    logic [2:0][1:0]  idx;
    logic [2:0][9:0]  cc;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         mem_wr_sig;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wr_data;
  logic [127:0] probe_data;
  logic [127:0] expected_data;
  logic [3:0]   probe_en;

  wire [2:0]      crn_v;
  wire [2:0]      done_v;
  wire [2:0]      pass_v;
  wire [2:0][1:0] fc_v;
  wire [2:0][1:0] mi_v;
  wire [8:0]      cc_a;
  wire [5:0]      cc_b;
  wire [5:0]      cc_c;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cpu_test_monitor #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_PROBES(4), .TOHOST_ADDR(TOHOST_P),
    .RESET_CYCLES(3), .TIMEOUT_CYCLES(500), .REQUIRE_TOHOST(0)
  ) u_a (
    .clk(clk), .reset_n(reset_n), .mem_wr_sig(mem_wr_sig), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .probe_data(probe_data), .expected_data(expected_data),
    .probe_en(probe_en), .cpu_reset_n(crn_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .fail_code(fc_v[0]), .mismatch_idx(mi_v[0]), .cycle_count(cc_a)
  );

  cpu_test_monitor #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_PROBES(4), .TOHOST_ADDR(TOHOST_P),
    .RESET_CYCLES(1), .TIMEOUT_CYCLES(41), .REQUIRE_TOHOST(0)
  ) u_b (
    .clk(clk), .reset_n(reset_n), .mem_wr_sig(mem_wr_sig), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .probe_data(probe_data), .expected_data(expected_data),
    .probe_en(probe_en), .cpu_reset_n(crn_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .fail_code(fc_v[1]), .mismatch_idx(mi_v[1]), .cycle_count(cc_b)
  );

  cpu_test_monitor #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .NUM_PROBES(4), .TOHOST_ADDR(TOHOST_P),
    .RESET_CYCLES(2), .TIMEOUT_CYCLES(60), .REQUIRE_TOHOST(1)
  ) u_c (
    .clk(clk), .reset_n(reset_n), .mem_wr_sig(mem_wr_sig), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .probe_data(probe_data), .expected_data(expected_data),
    .probe_en(probe_en), .cpu_reset_n(crn_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .fail_code(fc_v[2]), .mismatch_idx(mi_v[2]), .cycle_count(cc_c)
  );

  function automatic int rc_of(input int d);
    case (d)
      0:       return 3;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic int to_of(input int d);
    case (d)
      0:       return 500;
      1:       return 41;
      default: return 60;
    endcase
  endfunction

  function automatic int rt_of(input int d);
    return (d == 2) ? 1 : 0;
  endfunction

  function automatic int out_cc(input int d);
    case (d)
      0:       return int'(cc_a);
      1:       return int'(cc_b);
      default: return int'(cc_c);
    endcase
  endfunction

  // Scenario-level model: the run ends on the first counted tohost store, else after
  // TIMEOUT run cycles; the verdict follows the documented priority.
  function automatic void model(input int d, input int s, input logic [31:0] sd,
                                input logic [127:0] pd, input logic [127:0] ed,
                                input logic [3:0] en, output int end_e, output int code,
                                output int idx);
    int  first;
    int  last;
    bit  th;
    bit  found;
    first = rc_of(d) + 1;            // first edge seen in RUN
    last  = rc_of(d) + to_of(d);     // edge on which the count hits TIMEOUT
    th    = (s >= first) && (s <= last);
    end_e = th ? s : last;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && en[i] && (pd[i*32 +: 32] != ed[i*32 +: 32])) begin
        idx   = i;
        found = 1'b1;
      end
    end
    if ((rt_of(d) != 0) && !th)  code = 3;
    else if (th && (sd != 32'd1)) code = 1;
    else if (found)               code = 2;
    else                          code = 0;
  endfunction

  task automatic chk(input string name, input int d, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s dut%0d at %0t: got %0d, expected %0d", name, d, $time, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input int d);
    chk("rst cpu_reset_n", d, crn_v[d], 0);
    chk("rst done", d, done_v[d], 0);
    chk("rst pass", d, pass_v[d], 0);
    chk("rst fail_code", d, fc_v[d], 0);
    chk("rst mismatch_idx", d, mi_v[d], 0);
    chk("rst cycle_count", d, out_cc(d), 0);
  endtask

  task automatic run(input vec_t v, input bit use_table);
    int end_e [3];
    int code_e [3];
    int idx_e [3];
    int cc_e [3];
    int t_end, t_code, t_idx;
    int max_end;
    int r;
    int cc_now;
    max_end = 0;
    for (int d = 0; d < 3; d++) begin
      model(d, v.s, v.sd, v.pd, v.ed, v.en, t_end, t_code, t_idx);
      end_e[d] = t_end;
      if (use_table) begin
        code_e[d] = int'(v.code[d]);
        idx_e[d]  = int'(v.idx[d]);
        cc_e[d]   = int'(v.cc[d]);
      end else begin
        code_e[d] = t_code;
        idx_e[d]  = t_idx;
        cc_e[d]   = t_end - rc_of(d);
      end
      if (t_end > max_end) max_end = t_end;
    end

    reset_n       = 1'b0;
    mem_wr_sig    = 1'b0;
    mem_addr      = '0;
    mem_wr_data   = '0;
    probe_data    = v.pd;
    expected_data = v.ed;
    probe_en      = v.en;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) chk_reset_vals(d);
    reset_n = 1'b1;

    for (int e = 0; e <= max_end + 5; e++) begin
      r           = $urandom_range(0, 9);
      mem_wr_sig  = 1'b0;
      mem_addr    = $urandom();
      mem_wr_data = $urandom();
      if (r < 2) begin
        // Store to an address one bit away from tohost.
        mem_wr_sig = 1'b1;
        mem_addr   = TOHOST_32 ^ (32'd1 << $urandom_range(0, 31));
      end else if (r == 2) begin
        mem_addr = TOHOST_32;
      end
      if (e == v.s) begin
        mem_wr_sig  = 1'b1;
        mem_addr    = TOHOST_32;
        mem_wr_data = v.sd;
      end
      if (e > max_end + 2) probe_data = {$urandom(), $urandom(), $urandom(), $urandom()};
      if (e == v.abort) reset_n = 1'b0;
      @(posedge clk);
      #1;
      if (e == v.abort) begin
        for (int d = 0; d < 3; d++) chk_reset_vals(d);
        return;
      end
      for (int d = 0; d < 3; d++) begin
        chk("cpu_reset_n", d, crn_v[d], (e >= rc_of(d)) ? 1 : 0);
        chk("done", d, done_v[d], (e >= end_e[d] + 2) ? 1 : 0);
        if (e <= rc_of(d))       cc_now = 0;
        else if (e < end_e[d])   cc_now = e - rc_of(d);
        else                     cc_now = end_e[d] - rc_of(d);
        chk("cycle_count", d, out_cc(d), cc_now);
      end
    end

    for (int d = 0; d < 3; d++) begin
      chk("final done", d, done_v[d], 1);
      chk("final pass", d, pass_v[d], (code_e[d] == 0) ? 1 : 0);
      chk("final fail_code", d, fc_v[d], code_e[d]);
      chk("final mismatch_idx", d, mi_v[d], idx_e[d]);
      chk("final cycle_count", d, out_cc(d), cc_e[d]);
    end
  endtask

  function automatic vec_t mk(input int s, input logic [31:0] sd, input logic [127:0] pd,
                              input logic [127:0] ed, input logic [3:0] en, input int abort,
                              input logic [2:0][1:0] code, input logic [2:0][1:0] idx,
                              input logic [2:0][9:0] cc);
    vec_t v;
    v.s = s; v.sd = sd; v.pd = pd; v.ed = ed; v.en = en; v.abort = abort;
    v.code = code; v.idx = idx; v.cc = cc;
    return v;
  endfunction

  vec_t tbl [9];
  vec_t rv;

  initial begin
    logic [127:0] ok;
    ok = {32'd4, 32'd3, 32'd2, 32'd55};
    // Instances: a = hold 3 / timeout 500, b = hold 1 / timeout 41, c = hold 2 / timeout 60
    // with tohost required. Packed expectation order is {c, b, a}.
    // Store 1 on b's run cycle 40, coinciding with b's timeout: tohost wins everywhere.
    tbl[0] = mk(42, 32'd1, ok, ok, 4'b1111, -1,
                {2'd0, 2'd0, 2'd0}, {2'd0, 2'd0, 2'd0}, {10'd40, 10'd41, 10'd39});
    // Same store with data 5; lane 2 also mismatches but the tohost code takes priority.
    tbl[1] = mk(42, 32'd5, {32'd4, 32'd7, 32'd2, 32'd55}, ok, 4'b1111, -1,
                {2'd1, 2'd1, 2'd1}, {2'd2, 2'd2, 2'd2}, {10'd40, 10'd41, 10'd39});
    // No store, x29 == 55: timeouts; c fails for the missing tohost.
    tbl[2] = mk(-1, 32'd0, ok, ok, 4'b0001, -1,
                {2'd3, 2'd0, 2'd0}, {2'd0, 2'd0, 2'd0}, {10'd60, 10'd41, 10'd500});
    // x29 corrupted to 54.
    tbl[3] = mk(-1, 32'd0, {32'd4, 32'd3, 32'd2, 32'd54}, ok, 4'b0001, -1,
                {2'd3, 2'd2, 2'd2}, {2'd0, 2'd0, 2'd0}, {10'd60, 10'd41, 10'd500});
    // Lanes 1 and 3 mismatch, lane 1 disabled.
    tbl[4] = mk(-1, 32'd0, {32'd99, 32'd3, 32'd77, 32'd55}, ok, 4'b1101, -1,
                {2'd3, 2'd2, 2'd2}, {2'd3, 2'd3, 2'd3}, {10'd60, 10'd41, 10'd500});
    // reset_n pulled low mid-RUN.
    tbl[5] = mk(-1, 32'd0, ok, ok, 4'b1111, 20,
                {2'd0, 2'd0, 2'd0}, {2'd0, 2'd0, 2'd0}, {10'd0, 10'd0, 10'd0});
    // Store on edge 2: counted by b, on c's release edge and in a's HOLD (both ignore it).
    // All lanes disabled, so probes pass despite differences.
    tbl[6] = mk(2, 32'd1, {32'd1, 32'd2, 32'd3, 32'd4}, ok, 4'b0000, -1,
                {2'd3, 2'd0, 2'd0}, {2'd0, 2'd0, 2'd0}, {10'd60, 10'd1, 10'd500});
    // Store on edge 3: a's release edge (ignored), first RUN edge of c.
    tbl[7] = mk(3, 32'd1, ok, ok, 4'b1111, -1,
                {2'd0, 2'd0, 2'd0}, {2'd0, 2'd0, 2'd0}, {10'd1, 10'd2, 10'd500});
    // Top-bit difference on lane 0 must count as a mismatch.
    tbl[8] = mk(10, 32'd1, {32'd4, 32'd3, 32'd2, 32'h8000_0037}, ok, 4'b0001, -1,
                {2'd2, 2'd2, 2'd2}, {2'd0, 2'd0, 2'd0}, {10'd8, 10'd9, 10'd7});

    for (int i = 0; i < 9; i++) run(tbl[i], 1'b1);

    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 3) == 0) rv.s = -1;
      else                           rv.s = int'($urandom_range(0, 70));
      if ($urandom_range(0, 1) == 1) rv.sd = 32'd1;
      else                           rv.sd = $urandom();
      rv.pd = {$urandom(), $urandom(), $urandom(), $urandom()};
      rv.ed = rv.pd;
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 1) == 1) rv.ed[i*32 +: 32] ^= (32'd1 << $urandom_range(0, 31));
      end
      rv.en = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) rv.abort = int'($urandom_range(0, 60));
      else                           rv.abort = -1;
      rv.code = '0;
      rv.idx  = '0;
      rv.cc   = '0;
      run(rv, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
